// File: rtl/cix32_pipe_chain.sv
// Elastic chain of STAGES payload slots with valid/ready at both ends,
// per-slot stall and kill, global flush, occupancy and a saturating squash counter.
module cix32_pipe_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  input  logic [STAGES-1:0]                stall,
  input  logic [STAGES-1:0]                kill,
  input  logic                             flush,
  output logic [STAGES-1:0]                stage_valid,
  output logic [$clog2(STAGES+1)-1:0]      occupancy,
  output logic [CNT_W-1:0]                 squash_count
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] pass;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] squashed;
  logic [OCC_W-1:0]  occ_cnt;
  logic [OCC_W-1:0]  sq_inc;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [OCC_W-1:0] popcnt(input logic [STAGES-1:0] x);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = c + OCC_W'(x[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [OCC_W-1:0] b);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] lim;
    s   = SUM_W'(a) + SUM_W'(b);
    lim = SUM_W'({CNT_W{1'b1}});
    return (s > lim) ? {CNT_W{1'b1}} : CNT_W'(s);
  endfunction

  // Ready ripples from out_ready back toward slot 0; each slot sees the
  // accept of the slot after it.
  always_comb begin
    logic down_acc;
    ev       = '0;
    pass     = '0;
    acc      = '0;
    down_acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ev[i]    = v_q[i] & ~kill[i] & ~flush;
      pass[i]  = ev[i] & ~stall[i] & down_acc;
      acc[i]   = ~stall[i] & (~ev[i] | pass[i]) & ~flush;
      down_acc = acc[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_slot
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      logic             v_r;
      logic [WIDTH-1:0] d_r;

      if (g == 0) begin : g_head
        assign src_v = in_valid;
        assign src_d = in_data;
      end else begin : g_body
        assign src_v = pass[g-1];
        assign src_d = d_q[g-1];
      end

      // Slot register: load from upstream when accepting, otherwise hold
      // unless the resident entry is squashed.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_r <= 1'b0;
          d_r <= '0;
        end else if (acc[g]) begin
          v_r <= src_v;
          if (src_v) begin
            d_r <= src_d;
          end
        end else if (kill[g] | flush) begin
          v_r <= 1'b0;
        end
      end

      assign v_q[g] = v_r;
      assign d_q[g] = d_r;
    end
  endgenerate

  assign squashed = v_q & (kill | {STAGES{flush}});
  assign sq_inc   = popcnt(squashed);
  assign occ_cnt  = popcnt(v_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= sat_add(cnt_q, sq_inc);
    end
  end

  assign in_ready     = acc[0];
  assign out_valid    = ev[STAGES-1] & ~stall[STAGES-1];
  assign out_data     = d_q[STAGES-1];
  assign stage_valid  = v_q;
  assign occupancy    = occ_cnt;
  assign squash_count = cnt_q;

endmodule
